// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, next-PC selection and IF/ID pipeline register for a single-issue fetch
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchOff,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] JrTarget,
  output logic [31:0] Addr,
  input  logic [31:0] Inst,
  output logic [31:0] IdInst,
  output logic [31:0] IdPcPlus4,
  output logic        IdValid,
  output logic        AlignErr
);
  logic [29:0] pc;
  logic [1:0]  src;
  logic        redirect;
  logic [31:0] pc_plus4, target;
  assign Addr = {pc, 2'b00};
  assign pc_plus4 = Addr + 32'd4;
  // a bubble in decode cannot request a redirect
  assign src = IdValid ? PCSrc : 2'b00;
  assign redirect = src != 2'b00;
  always_comb
    target = src == 2'b01 ? IdPcPlus4 + {BranchOff[29:0], 2'b00} :
             src == 2'b10 ? {IdPcPlus4[31:28], JumpIndex, 2'b00} :
                            {JrTarget[31:2], 2'b00};
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc        <= RESET_PC[31:2];
      IdInst    <= NOP_INST;
      IdPcPlus4 <= 32'd0;
      IdValid   <= 1'b0;
      AlignErr  <= 1'b0;
    end else begin
      pc <= redirect ? target[31:2] : Stall ? pc : pc_plus4[31:2];
      if (src == 2'b11 && JrTarget[1:0] != 2'b00) AlignErr <= 1'b1;
      if (redirect || Flush) begin
        IdInst    <= NOP_INST;
        IdPcPlus4 <= 32'd0;
        IdValid   <= 1'b0;
      end else if (!Stall) begin
        IdInst    <= Inst;
        IdPcPlus4 <= pc_plus4;
        IdValid   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and random stimulus against a behavioural fetch model
module tb_if_fetch_stage;
  logic        clk = 0, reset, stall, flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_off, jr_target, addr, inst, id_inst, id_pc_plus4;
  logic [25:0] jump_index;
  logic        id_valid, align_err;
  logic [31:0] addr2, inst2, id_inst2, id_pc_plus42;
  logic        id_valid2, align_err2;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_inst, m_pp4;
  logic        m_valid, m_err;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'd0 ? 32'h2001_0006 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign inst = rom(addr);
  assign inst2 = rom(addr2);

  if_fetch_stage dut (.Clk(clk), .Reset(reset), .Stall(stall), .Flush(flush), .PCSrc(pc_src),
    .BranchOff(branch_off), .JumpIndex(jump_index), .JrTarget(jr_target), .Addr(addr), .Inst(inst),
    .IdInst(id_inst), .IdPcPlus4(id_pc_plus4), .IdValid(id_valid), .AlignErr(align_err));

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.Clk(clk), .Reset(reset), .Stall(1'b0),
    .Flush(1'b0), .PCSrc(2'b00), .BranchOff(32'd0), .JumpIndex(26'd0), .JrTarget(32'd0),
    .Addr(addr2), .Inst(inst2), .IdInst(id_inst2), .IdPcPlus4(id_pc_plus42), .IdValid(id_valid2),
    .AlignErr(align_err2));

  function automatic logic [31:0] model_target(input logic [1:0] s);
    case (s)
      2'b01:   return m_pp4 + (branch_off << 2);
      2'b10:   return {m_pp4[31:28], jump_index, 2'b00};
      default: return jr_target & ~32'd3;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc <= 32'd0; m_inst <= 32'd0; m_pp4 <= 32'd0; m_valid <= 1'b0; m_err <= 1'b0;
    end else if (m_valid && pc_src != 2'b00) begin
      m_pc <= model_target(pc_src);
      m_inst <= 32'd0; m_pp4 <= 32'd0; m_valid <= 1'b0;
      if (pc_src == 2'b11 && jr_target[1:0] != 2'b00) m_err <= 1'b1;
    end else begin
      if (!stall) m_pc <= m_pc + 32'd4;
      if (flush) begin
        m_inst <= 32'd0; m_pp4 <= 32'd0; m_valid <= 1'b0;
      end else if (!stall) begin
        m_inst <= rom(m_pc); m_pp4 <= m_pc + 32'd4; m_valid <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [1:0] p,
                      input logic [31:0] bo, input logic [25:0] ji, input logic [31:0] jt);
    reset = r; stall = s; flush = f; pc_src = p; branch_off = bo; jump_index = ji; jr_target = jt;
    @(posedge clk);
    #1;
    chk("model_addr", addr, m_pc);
    chk("model_id_inst", id_inst, m_inst);
    chk("model_id_pc_plus4", id_pc_plus4, m_pp4);
    chk("model_id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("model_align_err", {31'd0, align_err}, {31'd0, m_err});
  endtask

  task automatic seq_until(input logic [31:0] a);
    for (int i = 0; i < 64 && addr != a; i++) step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("reach_addr", addr, a);
  endtask

  initial begin
    step(1, 0, 0, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_align_err", {31'd0, align_err}, 32'd0);
    chk("rst_addr2", addr2, 32'hFFFF_FFF8);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("first_addr", addr, 32'd4);
    chk("first_id_inst", id_inst, 32'h2001_0006);
    chk("first_id_pc_plus4", id_pc_plus4, 32'd4);
    chk("first_id_valid", {31'd0, id_valid}, 32'd1);
    chk("wrap_addr2_a", addr2, 32'hFFFF_FFFC);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("second_addr", addr, 32'd8);
    chk("wrap_addr2_b", addr2, 32'd0);
    step(0, 1, 0, 2'b00, 0, 0, 0);
    step(0, 1, 0, 2'b00, 0, 0, 0);
    chk("stall_addr", addr, 32'd8);
    chk("stall_id_pc_plus4", id_pc_plus4, 32'd8);
    chk("stall_id_inst", id_inst, rom(32'd4));
    step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("unstall_addr", addr, 32'd12);
    seq_until(32'h44);
    chk("br_base", id_pc_plus4, 32'h44);
    step(0, 0, 0, 2'b01, 32'd3, 0, 0);
    chk("br_addr", addr, 32'h50);
    chk("br_bubble", {31'd0, id_valid}, 32'd0);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("br_fetch_valid", {31'd0, id_valid}, 32'd1);
    chk("br_fetch_inst", id_inst, rom(32'h50));
    chk("br_fetch_pp4", id_pc_plus4, 32'h54);
    seq_until(32'h68);
    step(0, 0, 0, 2'b10, 0, 26'h1C, 0);
    chk("j_addr", addr, 32'h70);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b11, 0, 0, 32'h6);
    chk("jr_addr", addr, 32'h4);
    chk("jr_align_err", {31'd0, align_err}, 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("align_err_sticky", {31'd0, align_err}, 32'd1);
    step(0, 1, 0, 2'b10, 0, 26'h40, 0);
    chk("stall_j_addr", addr, 32'h100);
    chk("stall_j_bubble", {31'd0, id_valid}, 32'd0);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 1, 2'b00, 0, 0, 0);
    chk("flush_addr", addr, 32'h108);
    chk("flush_bubble", {31'd0, id_valid}, 32'd0);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b01, 32'd5, 0, 0);
    chk("mid_rst_addr", addr, 32'd0);
    chk("mid_rst_valid", {31'd0, id_valid}, 32'd0);
    chk("mid_rst_align_err", {31'd0, align_err}, 32'd0);
    chk("mid_rst_addr2", addr2, 32'hFFFF_FFF8);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] jt;
      jt = $urandom();
      if ($urandom_range(3) != 0) jt[1:0] = 2'b00;
      step($urandom_range(49) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0,
           $urandom_range(2) == 0 ? 2'($urandom_range(3)) : 2'b00,
           {{16{1'b1}}, 16'($urandom())} ^ ($urandom_range(1) ? 32'hFFFF_0000 : 32'd0),
           26'($urandom()), jt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
